// File: rtl/id_operand_stage.sv
// ID/EX operand stage: drives register file reads, resolves operands (WB bypass, optional MEM
// forwarding), stalls on RAW/load-use hazards. Define FWD_ID_EX_EN to enable MEM-stage ALU forwarding.
module id_operand_stage #(
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic              in_use_rs1,
   input  logic              in_use_rs2,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_raddr1,
   output logic [4:0]        rf_raddr2,
   input  logic [31:0]       rf_rdata1,
   input  logic [31:0]       rf_rdata2,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rd,
   input  logic [31:0]       wb_data,
   input  logic              mem_reg_write,
   input  logic              mem_mem_read,
   input  logic [4:0]        mem_rd,
   input  logic [31:0]       mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rs1_data,
   output logic [31:0]       out_rs2_data,
   output logic [4:0]        out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_imm,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [15:0]       stall_count,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high; the
   // sender keeps valid and payload stable until then, and ready may depend on the payload.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_out_valid;
   logic [31:0]         r_rs1_data;
   logic [31:0]         r_rs2_data;
   logic [4:0]          r_rd;
   logic                r_reg_write;
   logic                r_mem_read;
   logic [31:0]         r_pc;
   logic [31:0]         r_imm;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [15:0]         r_stall_count;

   logic                w_empty;
   logic                w_ex_match1;
   logic                w_ex_match2;
   logic                w_raw1;
   logic                w_raw2;
   logic                w_hz1;
   logic                w_hz2;
   logic                w_hazard;
   logic                w_accept;
   logic                w_bubble;
   logic [31:0]         w_op1;
   logic [31:0]         w_op2;

   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

   assign w_empty     = ~r_out_valid | out_ready;
   assign w_ex_match1 = r_out_valid & (r_rd == in_rs1);
   assign w_ex_match2 = r_out_valid & (r_rd == in_rs2);

`ifdef FWD_ID_EX_EN
   assign w_raw1 = 1'b0;
   assign w_raw2 = 1'b0;
`else
   // Without forwarding, any in-flight producer ahead of WB must drain first.
   assign w_raw1 = (w_ex_match1 & r_reg_write) | (mem_reg_write & (mem_rd == in_rs1));
   assign w_raw2 = (w_ex_match2 & r_reg_write) | (mem_reg_write & (mem_rd == in_rs2));
   logic w_unused_mem;
   assign w_unused_mem = ^{mem_data, mem_mem_read};
`endif

   assign w_hz1    = in_use_rs1 & (in_rs1 != 5'd0) & ((w_ex_match1 & r_mem_read) | w_raw1);
   assign w_hz2    = in_use_rs2 & (in_rs2 != 5'd0) & ((w_ex_match2 & r_mem_read) | w_raw2);
   assign w_hazard = in_valid & (w_hz1 | w_hz2);
   assign in_ready = rst & w_empty & ~w_hazard & ~flush;
   assign w_accept = in_valid & in_ready;
   assign w_bubble = w_empty & w_hazard & ~flush;

   always_comb begin
      w_op1 = rf_rdata1;
      if (in_rs1 == 5'd0) begin
         w_op1 = 32'd0;
`ifdef FWD_ID_EX_EN
      end else if (mem_reg_write & ~mem_mem_read & (mem_rd == in_rs1)) begin
         w_op1 = mem_data;
`endif
      end else if (wb_reg_write & (wb_rd == in_rs1)) begin
         w_op1 = wb_data;
      end
   end

   always_comb begin
      w_op2 = rf_rdata2;
      if (in_rs2 == 5'd0) begin
         w_op2 = 32'd0;
`ifdef FWD_ID_EX_EN
      end else if (mem_reg_write & ~mem_mem_read & (mem_rd == in_rs2)) begin
         w_op2 = mem_data;
`endif
      end else if (wb_reg_write & (wb_rd == in_rs2)) begin
         w_op2 = wb_data;
      end
   end

   always_comb begin
      w_state_next = ST_RUN;
      if (flush) begin
         w_state_next = ST_RUN;
      end else if (w_bubble) begin
         w_state_next = ST_STALL;
      end else if (!w_empty) begin
         w_state_next = ST_HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid   <= 1'b0;
         r_rs1_data    <= 32'd0;
         r_rs2_data    <= 32'd0;
         r_rd          <= 5'd0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_pc          <= 32'd0;
         r_imm         <= 32'd0;
         r_ctrl        <= '0;
         r_stall_count <= 16'd0;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1_data  <= w_op1;
            r_rs2_data  <= w_op2;
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_mem_read  <= in_mem_read;
            r_pc        <= in_pc;
            r_imm       <= in_imm;
            r_ctrl      <= in_ctrl;
         end else if (w_empty) begin
            r_out_valid <= 1'b0;
         end
         if (w_bubble && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end

   assign out_valid     = r_out_valid;
   assign out_rs1_data  = r_rs1_data;
   assign out_rs2_data  = r_rs2_data;
   assign out_rd        = r_rd;
   assign out_reg_write = r_reg_write;
   assign out_mem_read  = r_mem_read;
   assign out_pc        = r_pc;
   assign out_imm       = r_imm;
   assign out_ctrl      = r_ctrl;
   assign stall_count   = r_stall_count;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: spec-level model compared every cycle plus directed literal checks.
// Expectations follow FWD_ID_EX_EN when it is defined.
module tb_id_operand_stage;
   localparam int CTRL_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4:0]        in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic              in_use_rs1 = 1'b0, in_use_rs2 = 1'b0;
   logic              in_reg_write = 1'b0, in_mem_read = 1'b0;
   logic [31:0]       in_pc = '0, in_imm = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [4:0]        rf_raddr1, rf_raddr2;
   logic [31:0]       rf_rdata1, rf_rdata2;
   logic              wb_reg_write = 1'b0;
   logic [4:0]        wb_rd = '0;
   logic [31:0]       wb_data = '0;
   logic              mem_reg_write = 1'b0, mem_mem_read = 1'b0;
   logic [4:0]        mem_rd = '0;
   logic [31:0]       mem_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [31:0]       out_rs1_data, out_rs2_data;
   logic [4:0]        out_rd;
   logic              out_reg_write, out_mem_read;
   logic [31:0]       out_pc, out_imm;
   logic [CTRL_W-1:0] out_ctrl;
   logic [15:0]       stall_count;
   logic [1:0]        dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   int          waits;
   logic [15:0] exp_stall;

   id_operand_stage #(.CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_pc(in_pc), .in_imm(in_imm), .in_ctrl(in_ctrl),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_rd(mem_rd), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_pc(out_pc), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .stall_count(stall_count), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // register file contents: a fixed, address-derived pattern
   function automatic logic [31:0] rf_val(input logic [4:0] a);
      return 32'hA000_0000 | {27'd0, a};
   endfunction
   assign rf_rdata1 = rf_val(rf_raddr1);
   assign rf_rdata2 = rf_val(rf_raddr2);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model of the ID/EX register
   logic              m_valid;
   logic [4:0]        m_rd;
   logic              m_rw, m_mr;
   logic [31:0]       m_pc, m_imm, m_d1, m_d2;
   logic [CTRL_W-1:0] m_ctrl;
   logic [15:0]       m_stall;

   function automatic logic m_src_hazard(input logic used, input logic [4:0] rs);
      if (!used || rs == 5'd0) return 1'b0;
      if (m_valid && m_mr && m_rd == rs) return 1'b1;
`ifndef FWD_ID_EX_EN
      if (m_valid && m_rw && m_rd == rs) return 1'b1;
      if (mem_reg_write && mem_rd == rs) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic m_hazard();
      return in_valid && (m_src_hazard(in_use_rs1, in_rs1) || m_src_hazard(in_use_rs2, in_rs2));
   endfunction

   function automatic logic m_empty();
      return !m_valid || out_ready;
   endfunction

   function automatic logic m_ready();
      return rst && m_empty() && !m_hazard() && !flush;
   endfunction

   function automatic logic [31:0] m_operand(input logic [4:0] rs);
      if (rs == 5'd0) return 32'd0;
`ifdef FWD_ID_EX_EN
      if (mem_reg_write && !mem_mem_read && mem_rd == rs) return mem_data;
`endif
      if (wb_reg_write && wb_rd == rs) return wb_data;
      return rf_val(rs);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_stall <= 16'd0;
         m_rd <= '0; m_rw <= 1'b0; m_mr <= 1'b0;
         m_pc <= '0; m_imm <= '0; m_d1 <= '0; m_d2 <= '0; m_ctrl <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
      end else if (in_valid && m_ready()) begin
         m_valid <= 1'b1;
         m_d1 <= m_operand(in_rs1);
         m_d2 <= m_operand(in_rs2);
         m_rd <= in_rd; m_rw <= in_reg_write; m_mr <= in_mem_read;
         m_pc <= in_pc; m_imm <= in_imm; m_ctrl <= in_ctrl;
      end else if (m_empty()) begin
         m_valid <= 1'b0;
         if (m_hazard() && m_stall != 16'hFFFF) m_stall <= m_stall + 16'd1;
      end
   end

   // compare process
   always @(negedge clk) begin
      check("in_ready", in_ready, m_ready());
      check("out_valid", out_valid, m_valid);
      check("stall_count", stall_count, m_stall);
      check("rf_raddr1", rf_raddr1, in_rs1);
      check("rf_raddr2", rf_raddr2, in_rs2);
      if (rst && m_valid) begin
         check("out_rs1_data", out_rs1_data, m_d1);
         check("out_rs2_data", out_rs2_data, m_d2);
         check("out_rd", out_rd, m_rd);
         check("out_reg_write", out_reg_write, m_rw);
         check("out_mem_read", out_mem_read, m_mr);
         check("out_pc", out_pc, m_pc);
         check("out_imm", out_imm, m_imm);
         check("out_ctrl", out_ctrl, m_ctrl);
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic env_idle();
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0; mem_data = '0;
   endtask

   task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic rw, input logic mr,
                          input logic [31:0] pc);
      in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_use_rs1 = u1; in_use_rs2 = u2;
      in_reg_write = rw; in_mem_read = mr;
      in_pc = pc; in_imm = pc + 32'h1000;
      in_ctrl = pc[15:0] ^ 16'h5A5A;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept(input int max_wait, output int n_wait);
      logic done;
      done = 1'b0;
      n_wait = 0;
      while (!done && n_wait <= max_wait) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else n_wait++;
         step();
      end
      check("accept_in_time", done, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw, input logic mr,
                       input logic [31:0] pc, input int exp_wait);
      present(rs1, rs2, rd, u1, u2, rw, mr, pc);
      wait_accept(8, waits);
      check("bubble_cycles", waits, exp_wait);
   endtask

   initial begin
      exp_stall = 16'd0;
      env_idle();
      // reset state, with an input offered
      #2;
      present(5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
      #1;
      check("reset_in_ready", in_ready, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_stall", stall_count, 16'd0);
      check("reset_rs1_data", out_rs1_data, 32'd0);
      step();
      rst = 1'b1;

      // first accept after reset, 1-cycle latency
      send(5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 0);
      check("first_valid", out_valid, 1'b1);
      check("first_rs1", out_rs1_data, 32'hA000_0002);
      check("first_rd", out_rd, 5'd7);
      check("first_pc", out_pc, 32'h100);

      // WB same-cycle bypass, x0 reads zero
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      send(5'd5, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 0);
      check("wb_bypass_rs1", out_rs1_data, 32'hDEADBEEF);
      check("x0_rs2", out_rs2_data, 32'd0);
      wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      send(5'd0, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h108, 0);
      check("x0_with_wb_rd0", out_rs1_data, 32'd0);
      check("rf_rs2", out_rs2_data, 32'hA000_0005);
      env_idle();

      // load-use: lw x3 ; add x4,x3,x3
      send(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10C, 0);
      wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_1234;
      send(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h110, 1);
      exp_stall = exp_stall + 16'd1;
      check("loaduse_rs1", out_rs1_data, 32'h0000_1234);
      check("loaduse_rs2", out_rs2_data, 32'h0000_1234);
      check("loaduse_stall", stall_count, exp_stall);
      env_idle();

      // ALU RAW: add x1 ; sub x2,x1,x1
      send(5'd2, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h114, 0);
      present(5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h118);
`ifdef FWD_ID_EX_EN
      mem_reg_write = 1'b1; mem_rd = 5'd1; mem_data = 32'h10;
      @(negedge clk);
      check("raw_fwd_ready", in_ready, 1'b1);
      step();
`else
      @(negedge clk);
      check("raw_ex_stall", in_ready, 1'b0);
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd1; mem_data = 32'h10;
      @(negedge clk);
      check("raw_mem_stall", in_ready, 1'b0);
      step();
      env_idle();
      wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h10;
      @(negedge clk);
      check("raw_wb_ready", in_ready, 1'b1);
      step();
      exp_stall = exp_stall + 16'd2;
`endif
      in_valid = 1'b0;
      check("raw_rs1", out_rs1_data, 32'h10);
      check("raw_rs2", out_rs2_data, 32'h10);
      check("raw_stall", stall_count, exp_stall);
      env_idle();

      // a load in MEM never forwards its mem_data
      mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd6; mem_data = 32'hBAD0_BAD0;
      present(5'd6, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11C);
`ifndef FWD_ID_EX_EN
      @(negedge clk);
      check("mem_load_stall", in_ready, 1'b0);
      step();
      env_idle();
      exp_stall = exp_stall + 16'd1;
`endif
      @(negedge clk);
      check("mem_load_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("mem_load_rs1", out_rs1_data, 32'hA000_0006);
      check("mem_load_stall_cnt", stall_count, exp_stall);
      env_idle();

      // HOLD: downstream not ready for 3 cycles
      send(5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 0);
      out_ready = 1'b0;
      present(5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_in_ready", in_ready, 1'b0);
         check("hold_valid", out_valid, 1'b1);
         check("hold_rs1", out_rs1_data, 32'hA000_000A);
         check("hold_rs2", out_rs2_data, 32'hA000_000B);
         check("hold_rd", out_rd, 5'd12);
         check("hold_stall", stall_count, exp_stall);
         step();
      end
      check("hold_state", dbg_state, 2'd2);
      out_ready = 1'b1;
      @(negedge clk);
      check("hold_release_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("after_hold_rs1", out_rs1_data, 32'hA000_000D);
      check("after_hold_pc", out_pc, 32'h304);

      // flush during STALL
      send(5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 0);
      present(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h404);
      @(negedge clk);
      check("flush_pre_stall", in_ready, 1'b0);
      step();
      exp_stall = exp_stall + 16'd1;
      flush = 1'b1;
      @(negedge clk);
      check("stall_state", dbg_state, 2'd1);
      check("flush_in_ready", in_ready, 1'b0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_state_run", dbg_state, 2'd0);
      check("flush_stall", stall_count, exp_stall);

      // flush wins over HOLD
      send(5'd2, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 0);
      out_ready = 1'b0;
      flush = 1'b1;
      step();
      check("flush_over_hold", out_valid, 1'b0);
      flush = 1'b0;
      out_ready = 1'b1;

`ifndef FWD_ID_EX_EN
      // bubble counter saturation under a persistent MEM hazard
      mem_reg_write = 1'b1; mem_rd = 5'd9;
      present(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600);
      repeat (65540) step();
      check("stall_saturated", stall_count, 16'hFFFF);
      in_valid = 1'b0;
      env_idle();
      step();
`endif

      // reset mid-transfer, then re-present
      send(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 0);
      present(5'd4, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h704);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_valid", out_valid, 1'b0);
      check("midreset_stall", stall_count, 16'd0);
      check("midreset_rs1", out_rs1_data, 32'd0);
      check("midreset_pc", out_pc, 32'd0);
      check("midreset_in_ready", in_ready, 1'b0);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_ready", in_ready, 1'b1);
      check("post_reset_valid", out_valid, 1'b0);
      step();
      in_valid = 1'b0;
      check("post_reset_latency", out_valid, 1'b1);
      check("post_reset_rs1", out_rs1_data, 32'hA000_0004);
      check("post_reset_rd", out_rd, 5'd6);

      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
